// File: rtl/u_xmit.sv
// u_xmit: UART transmitter, 1 start bit, 8 data bits LSB first, 1 stop bit.
// Each bit cell lasts BIT_CELL sys_clk cycles. All outputs are registered.
// Optional feature: define XMIT_TWO_STOP_EN to stretch the stop cell to two bit times.
module u_xmit #(
    parameter int unsigned BIT_CELL = 16,
    parameter int unsigned WORD_LEN = 8
) (
    input  logic                sys_clk,
    input  logic                sys_rstH,
    input  logic                xmitH,
    input  logic [WORD_LEN-1:0] xmit_dataH,
    output logic                uart_xmitH,
    output logic                xmit_busyH,
    output logic                xmit_doneH
);

    localparam int unsigned CntW = (BIT_CELL > 1) ? $clog2(BIT_CELL) : 1;
    localparam int unsigned BitW = $clog2(WORD_LEN + 1);

    typedef enum logic [1:0] {x_IDLE, x_START, x_DATA, x_STOP} state_e;

    state_e              state_q;
    logic [CntW-1:0]     cell_cnt_q;
    logic [BitW-1:0]     bit_cnt_q;
    logic [WORD_LEN-1:0] shift_q;
    logic                line_q;
    logic                busy_q;
    logic                done_q;
    logic                cell_end;
    logic                stop_last;

`ifdef XMIT_TWO_STOP_EN
    logic                stop2_q;
`endif

    // A bit cell ends on the edge where the counter holds its top value.
    always_comb begin
        cell_end = (cell_cnt_q == CntW'(BIT_CELL - 1));
`ifdef XMIT_TWO_STOP_EN
        stop_last = stop2_q;
`else
        stop_last = 1'b1;
`endif
    end

    // Frame sequencer with registered line, busy and done outputs.
    always_ff @(posedge sys_clk) begin
        if (sys_rstH) begin
            state_q    <= x_IDLE;
            cell_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            line_q     <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
`ifdef XMIT_TWO_STOP_EN
            stop2_q    <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                x_IDLE: begin
                    line_q <= 1'b1;
                    busy_q <= 1'b0;
                    if (xmitH) begin
                        shift_q    <= xmit_dataH;
                        cell_cnt_q <= '0;
                        bit_cnt_q  <= '0;
                        line_q     <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= x_START;
                    end
                end
                x_START: begin
                    if (cell_end) begin
                        cell_cnt_q <= '0;
                        line_q     <= shift_q[0];
                        shift_q    <= shift_q >> 1;
                        state_q    <= x_DATA;
                    end else begin
                        cell_cnt_q <= cell_cnt_q + 1'b1;
                    end
                end
                x_DATA: begin
                    if (cell_end) begin
                        cell_cnt_q <= '0;
                        if (bit_cnt_q == BitW'(WORD_LEN - 1)) begin
                            bit_cnt_q <= BitW'(WORD_LEN);
                            line_q    <= 1'b1;
                            state_q   <= x_STOP;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 1'b1;
                            line_q    <= shift_q[0];
                            shift_q   <= shift_q >> 1;
                        end
                    end else begin
                        cell_cnt_q <= cell_cnt_q + 1'b1;
                    end
                end
                x_STOP: begin
                    if (cell_end) begin
                        cell_cnt_q <= '0;
                        if (stop_last) begin
                            bit_cnt_q <= '0;
                            busy_q    <= 1'b0;
                            done_q    <= 1'b1;
                            state_q   <= x_IDLE;
`ifdef XMIT_TWO_STOP_EN
                            stop2_q   <= 1'b0;
`endif
                        end
`ifdef XMIT_TWO_STOP_EN
                        else begin
                            stop2_q <= 1'b1;
                        end
`endif
                    end else begin
                        cell_cnt_q <= cell_cnt_q + 1'b1;
                    end
                end
                default: begin
                    // Unreachable encoding: park safely with the line idle.
                    state_q    <= x_IDLE;
                    cell_cnt_q <= '0;
                    bit_cnt_q  <= '0;
                    line_q     <= 1'b1;
                    busy_q     <= 1'b0;
                end
            endcase
        end
    end

    assign uart_xmitH = line_q;
    assign xmit_busyH = busy_q;
    assign xmit_doneH = done_q;

endmodule

// File: tb/tb_u_xmit.sv
// tb_u_xmit: scoreboard bench for u_xmit. A frame-level model queues each accepted
// byte with its accept edge; a monitor decodes the serial line and checks on done.
module tb_u_xmit;

    localparam int BC = 16;
`ifdef XMIT_TWO_STOP_EN
    localparam int STOP_BITS = 2;
`else
    localparam int STOP_BITS = 1;
`endif
    localparam int FRAME = BC * (9 + STOP_BITS);

    logic       sys_clk;
    logic       sys_rstH;
    logic       xmitH;
    logic [7:0] xmit_dataH;
    logic       uart_xmitH;
    logic       xmit_busyH;
    logic       xmit_doneH;

    typedef struct {
        logic [7:0] data;
        int         e0;
    } frame_t;

    frame_t     exp_q[$];
    int         total = 0;
    int         bad = 0;
    int         n_edge = 0;
    int         last_end = 0;
    bit         rx_active = 0;
    int         rx_start = 0;
    int         off = 0;
    logic [7:0] rx_byte = '0;
    frame_t     f;

    u_xmit #(
        .BIT_CELL (BC),
        .WORD_LEN (8)
    ) dut (
        .sys_clk    (sys_clk),
        .sys_rstH   (sys_rstH),
        .xmitH      (xmitH),
        .xmit_dataH (xmit_dataH),
        .uart_xmitH (uart_xmitH),
        .xmit_busyH (xmit_busyH),
        .xmit_doneH (xmit_doneH)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, req, n_edge);
        end
    endtask

    task automatic tick();
        @(negedge sys_clk);
        #1;
    endtask

    // Frame-level model: a request is taken when no frame occupies the line.
    initial begin
        forever begin
            @(posedge sys_clk);
            n_edge++;
            if (sys_rstH) begin
                last_end = n_edge;
                exp_q.delete();
            end else if (xmitH && n_edge > last_end) begin
                exp_q.push_back('{data: xmit_dataH, e0: n_edge});
                last_end = n_edge + FRAME;
            end
        end
    end

    // Monitor: decode the line mid-cell and score each done pulse against the queue.
    initial begin
        forever begin
            @(negedge sys_clk);
            if (sys_rstH) begin
                chk("reset_line", uart_xmitH, 1);
                chk("reset_busy", xmit_busyH, 0);
                chk("reset_done", xmit_doneH, 0);
                rx_active = 0;
            end else begin
                chk("busy", xmit_busyH, int'(n_edge < last_end));
                if (n_edge >= last_end) chk("idle_line", uart_xmitH, 1);
                if (!rx_active && uart_xmitH == 1'b0) begin
                    rx_active = 1;
                    rx_start  = n_edge;
                end
                if (rx_active) begin
                    off = n_edge - rx_start;
                    if (off == BC / 2) chk("start_bit", uart_xmitH, 0);
                    for (int k = 0; k < 8; k++) begin
                        if (off == BC * (k + 1) + BC / 2) rx_byte[k] = uart_xmitH;
                    end
                    for (int s = 0; s < STOP_BITS; s++) begin
                        if (off == BC * (9 + s) + BC / 2) chk("stop_bit", uart_xmitH, 1);
                    end
                    if (off > FRAME) begin
                        chk("frame_overrun", off, FRAME);
                        rx_active = 0;
                    end
                end
                if (xmit_doneH) begin
                    if (exp_q.size() == 0) begin
                        chk("done_without_frame", exp_q.size(), 1);
                    end else begin
                        f = exp_q.pop_front();
                        chk("data", int'(rx_byte), int'(f.data));
                        chk("start_edge", rx_start, f.e0);
                        chk("done_edge", n_edge, f.e0 + FRAME);
                        chk("rx_in_frame", int'(rx_active), 1);
                        rx_active = 0;
                    end
                end
            end
        end
    end

    // Stimulus: directed cases followed by random traffic and a mid-frame reset.
    initial begin
        sys_rstH   = 1'b1;
        xmitH      = 1'b0;
        xmit_dataH = '0;
        repeat (3) tick();
        sys_rstH = 1'b0;
        repeat (50) tick();

        // Single frame of A5.
        xmit_dataH = 8'hA5;
        xmitH      = 1'b1;
        tick();
        xmitH      = 1'b0;
        xmit_dataH = 8'($urandom);
        repeat (FRAME + 10) tick();

        // Request 40 edges into a C3 frame must be dropped.
        xmit_dataH = 8'hC3;
        xmitH      = 1'b1;
        tick();
        xmitH = 1'b0;
        repeat (39) tick();
        xmit_dataH = 8'h3C;
        xmitH      = 1'b1;
        tick();
        xmitH = 1'b0;
        repeat (FRAME) tick();

        // Extreme patterns.
        for (int i = 0; i < 2; i++) begin
            xmit_dataH = (i == 0) ? 8'h00 : 8'hFF;
            xmitH      = 1'b1;
            tick();
            xmitH = 1'b0;
            repeat (FRAME + 3) tick();
        end

        // Request held high: back-to-back frames with random data.
        xmitH = 1'b1;
        for (int i = 0; i < 400; i++) begin
            xmit_dataH = 8'($urandom);
            tick();
        end
        xmitH = 1'b0;
        repeat (FRAME + 5) tick();

        // Random sparse requests, many landing mid-frame.
        for (int i = 0; i < 3000; i++) begin
            xmitH      = ($urandom_range(0, 40) == 0);
            xmit_dataH = 8'($urandom);
            tick();
        end
        xmitH = 1'b0;
        repeat (FRAME + 5) tick();

        // Reset 70 edges into a frame.
        xmit_dataH = 8'($urandom);
        xmitH      = 1'b1;
        tick();
        xmitH = 1'b0;
        repeat (69) tick();
        sys_rstH = 1'b1;
        tick();
        sys_rstH = 1'b0;
        repeat (FRAME + 5) tick();

        // Reset wins over a simultaneous request.
        sys_rstH = 1'b1;
        xmitH    = 1'b1;
        tick();
        sys_rstH = 1'b0;
        xmitH    = 1'b0;
        repeat (FRAME + 5) tick();

        chk("queue_drained", exp_q.size(), 0);
        chk("end_line", uart_xmitH, 1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/u_xmit.md
Name: u_xmit

Overview:
- UART transmitter; the transmit-side counterpart of the u_rec receiver in the RS232 block.
- Serialises one 8-bit word per request into the frame u_rec decodes: 1 start bit (low), 8 data bits LSB first, 1 stop bit (high).
- Each bit cell lasts BIT_CELL sys_clk cycles (default 16, matching the receiver's 16-clock sample spacing).
- Sits between the host/command logic and the uart_xmitH pin.

Parameters:
- BIT_CELL, 16: sys_clk cycles per serial bit; legal range 2..256; bit-cell counter width is clog2(BIT_CELL).
- WORD_LEN, 8: data bits per frame; fixed at 8 in this revision.

Ports:
- sys_clk     input   1  system clock; all logic on rising edge.
- sys_rstH    input   1  synchronous, active-high reset.
- xmitH       input   1  transmit request; sampled every rising edge.
- xmit_dataH  input   8  byte to send; captured on the accepting edge.
- uart_xmitH  output  1  serial line; idles high.
- xmit_busyH  output  1  high while a frame is in progress.
- xmit_doneH  output  1  one-cycle pulse when a frame completes.

Behaviour:
- Interface: one clock, sys_clk. Reset sys_rstH is synchronous and active-high.
- Reset values: uart_xmitH=1, xmit_busyH=0, xmit_doneH=0, state=x_IDLE, counters=0, shift register=0.
- Outputs: all outputs are registered; no combinational path from inputs to outputs.
- States: x_IDLE, x_START, x_DATA, x_STOP.
- x_IDLE:
  - If xmitH=1 at edge E0: latch xmit_dataH into the shift register, clear counters, go to x_START.
  - After E0: uart_xmitH=0 and xmit_busyH=1.
- x_START: hold line low for BIT_CELL cycles. At cell end, drive shift[0] and enter x_DATA.
- x_DATA:
  - Each cell end shifts right and increments the bit counter.
  - After the WORD_LEN-th data cell, drive 1 and enter x_STOP.
- x_STOP:
  - Hold line high for BIT_CELL cycles.
  - At cell end: return to x_IDLE, xmit_busyH=0, xmit_doneH=1 for exactly one cycle.
- Frame timing, counting edges from E0 (default BIT_CELL=16):
  - Start bit: line low after E0 through E16.
  - Data bit i: after E16·(i+1).
  - Stop bit: after E144.
  - Frame end: busy drops and done pulses after E160.
  - Total frame length: 10·BIT_CELL cycles.
- xmitH while busy (including the edge at which the stop bit ends): ignored, not queued; xmit_dataH changes while busy have no effect.
- Back-to-back frames:
  - xmitH held high is accepted on the first edge at which the state is x_IDLE.
  - The next start bit therefore follows after exactly one extra idle-high cycle beyond the stop cell.
- Bit-cell counter: counts 0..BIT_CELL-1 and wraps to 0 at each cell end. The data bit counter never exceeds WORD_LEN.
- Reset mid-frame: on the next edge the line returns high, busy drops, and done is not pulsed. Reset takes priority over xmitH.
- Illegal state encoding: recover to x_IDLE with line high.

Optional Feature:
- Macro: XMIT_TWO_STOP_EN.
- Defined:
  - x_STOP lasts 2·BIT_CELL cycles; frame length is 11·BIT_CELL.
  - done/busy-low occur after E176 at default settings.
  - Still decodable by u_rec.
- Undefined: one stop bit; frame length 10·BIT_CELL.

Test Plan:
- Reset then idle 50 cycles -> uart_xmitH=1, xmit_busyH=0, xmit_doneH=0 throughout.
- Single frame:
  - Stimulus: xmitH pulse with xmit_dataH=8'hA5.
  - Line: low 16 cycles, then bits 1,0,1,0,0,1,0,1 at 16 cycles each, then high.
  - Handshake: done pulses one cycle at E160; busy high E0..E160.
- Loopback: u_xmit output into u_rec, send 8'h00, 8'hFF, 8'h5A -> rec_dataH matches each byte, with one rec_readyH per frame.
- Busy ignore:
  - Stimulus: xmitH at E40 with data 8'h3C during a frame of 8'hC3.
  - Response: only 8'hC3 transmitted, single done pulse.
- Back-to-back: xmitH held high for 400 cycles -> start bits at E0 and E161; frames separated by exactly one idle cycle.
- Reset at E70 -> line high next cycle, busy=0, no done pulse. With XMIT_TWO_STOP_EN, a full frame shows done at E176.
